// File: rtl/imem_arbiter.sv
// Single-port instruction-RAM controller shared by the core fetch stage and the program loader.
// Fetch is held off in BOOT; in RUN the loader has priority, bounded so a waiting fetch is not starved.
module imem_arbiter #(
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned LDR_BURST_MAX = 4,
    parameter bit          BOOT_HOLD     = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              fetch_req_i,
    input  logic [31:0]       fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic              fetch_rvalid_o,
    output logic [31:0]       fetch_rdata_o,
    output logic              fetch_err_o,

    input  logic              ldr_req_i,
    input  logic              ldr_we_i,
    input  logic [31:0]       ldr_addr_i,
    input  logic [31:0]       ldr_wdata_i,
    output logic              ldr_gnt_o,
    output logic              ldr_rvalid_o,
    output logic [31:0]       ldr_rdata_o,
    output logic              ldr_err_o,
    input  logic              ldr_done_i,

    output logic              boot_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int unsigned CNT_W = $clog2(LDR_BURST_MAX + 1);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  burst_cnt;
    logic              burst_full;
    logic              fetch_addr_err;
    logic              ldr_addr_err;

    logic              resp_fetch;
    logic              resp_ldr;
    logic              resp_err;
    logic              resp_we;

    assign burst_full     = (burst_cnt == CNT_W'(LDR_BURST_MAX));
    assign fetch_addr_err = (|fetch_addr_i[1:0]) || (|fetch_addr_i[31:ADDR_W+2]);
    assign ldr_addr_err   = (|ldr_addr_i[1:0])   || (|ldr_addr_i[31:ADDR_W+2]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= BOOT_HOLD ? BOOT : RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == BOOT && ldr_done_i) begin
            state_nxt = RUN;
        end
    end

    // Grants are suppressed while reset is held, and responses in flight are masked
    // so nothing from before reset leaks into the cycle that follows it.
    always_comb begin
        fetch_gnt_o = 1'b0;
        ldr_gnt_o   = 1'b0;
        if (!rst_i) begin
            unique case (state)
                BOOT: begin
                    ldr_gnt_o = ldr_req_i;
                end
                RUN: begin
                    if (ldr_req_i && !(fetch_req_i && burst_full)) begin
                        ldr_gnt_o = 1'b1;
                    end else if (fetch_req_i) begin
                        fetch_gnt_o = 1'b1;
                    end
                end
            endcase
        end

        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (ldr_gnt_o && !ldr_addr_err) begin
            mem_en_o    = 1'b1;
            mem_we_o    = ldr_we_i;
            mem_addr_o  = ldr_addr_i[ADDR_W+1:2];
            mem_wdata_o = ldr_wdata_i;
        end else if (fetch_gnt_o && !fetch_addr_err) begin
            mem_en_o    = 1'b1;
            mem_addr_o  = fetch_addr_i[ADDR_W+1:2];
        end

        boot_o         = (state == BOOT);

        fetch_rvalid_o = resp_fetch && !rst_i;
        fetch_err_o    = fetch_rvalid_o && resp_err;
        fetch_rdata_o  = (fetch_rvalid_o && !resp_err) ? mem_rdata_i : '0;

        ldr_rvalid_o   = resp_ldr && !rst_i;
        ldr_err_o      = ldr_rvalid_o && resp_err;
        ldr_rdata_o    = (ldr_rvalid_o && !resp_err && !resp_we) ? mem_rdata_i : '0;
    end

    // Saturates so loader grants during BOOT cannot push the count past the bound.
    always_ff @(posedge clk_i) begin
        if (rst_i || !fetch_req_i || fetch_gnt_o) begin
            burst_cnt <= '0;
        end else if (ldr_gnt_o && !burst_full) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_fetch <= 1'b0;
            resp_ldr   <= 1'b0;
            resp_err   <= 1'b0;
            resp_we    <= 1'b0;
        end else begin
            resp_fetch <= fetch_gnt_o;
            resp_ldr   <= ldr_gnt_o;
            resp_err   <= ldr_gnt_o ? ldr_addr_err : (fetch_gnt_o && fetch_addr_err);
            resp_we    <= ldr_gnt_o && ldr_we_i;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural 1024x32 synchronous RAM.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt, fetch_rvalid, fetch_err;
    logic [31:0] fetch_rdata;
    logic        ldr_req, ldr_we, ldr_done;
    logic [31:0] ldr_addr, ldr_wdata;
    logic        ldr_gnt, ldr_rvalid, ldr_err;
    logic [31:0] ldr_rdata;
    logic        boot;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] ram [0:1023];

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [0:2];
    logic [31:0] pa   [0:2];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    imem_arbiter #(
        .ADDR_W       (10),
        .LDR_BURST_MAX(4),
        .BOOT_HOLD    (1'b1)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .fetch_req_i   (fetch_req),
        .fetch_addr_i  (fetch_addr),
        .fetch_gnt_o   (fetch_gnt),
        .fetch_rvalid_o(fetch_rvalid),
        .fetch_rdata_o (fetch_rdata),
        .fetch_err_o   (fetch_err),
        .ldr_req_i     (ldr_req),
        .ldr_we_i      (ldr_we),
        .ldr_addr_i    (ldr_addr),
        .ldr_wdata_i   (ldr_wdata),
        .ldr_gnt_o     (ldr_gnt),
        .ldr_rvalid_o  (ldr_rvalid),
        .ldr_rdata_o   (ldr_rdata),
        .ldr_err_o     (ldr_err),
        .ldr_done_i    (ldr_done),
        .boot_o        (boot),
        .mem_en_o      (mem_en),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        prog[0] = 32'h03200793; pa[0] = 32'h0;
        prog[1] = 32'h03100713; pa[1] = 32'h4;
        prog[2] = 32'h00E7F6B3; pa[2] = 32'h8;

        rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0; ldr_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_boot",      boot,         1);
        chk("rst_fgnt",      fetch_gnt,    0);
        chk("rst_lgnt",      ldr_gnt,      0);
        chk("rst_frvalid",   fetch_rvalid, 0);
        chk("rst_lrvalid",   ldr_rvalid,   0);
        chk("rst_frdata",    fetch_rdata,  0);
        chk("rst_lrdata",    ldr_rdata,    0);
        chk("rst_ferr",      fetch_err,    0);
        chk("rst_lerr",      ldr_err,      0);
        chk("rst_mem_en",    mem_en,       0);
        chk("rst_mem_we",    mem_we,       0);
        chk("rst_mem_addr",  mem_addr,     0);
        chk("rst_mem_wdata", mem_wdata,    0);
        tick();

        // fetch blocked in BOOT
        fetch_req = 1'b1; fetch_addr = 32'h0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("boot_fetch_blocked", fetch_gnt, 0);
            tick();
        end

        // loader writes back-to-back, fetch still waiting
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = pa[i]; ldr_wdata = prog[i];
            end else begin
                ldr_req = 1'b0; ldr_we = 1'b0;
            end
            #1;
            if (i < 3) begin
                chk("wr_gnt",      ldr_gnt,   1);
                chk("wr_fgnt",     fetch_gnt, 0);
                chk("wr_mem_we",   mem_we,    1);
                chk("wr_mem_addr", mem_addr,  i);
            end
            chk("wr_ack", ldr_rvalid, (i > 0) ? 1 : 0);
            chk("wr_ack_rdata", ldr_rdata, 0);
            chk("wr_ack_err",   ldr_err,   0);
            tick();
        end

        // loader read-back
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = pa[i];
            end else begin
                ldr_req = 1'b0;
            end
            #1;
            if (i < 3) chk("rd_gnt", ldr_gnt, 1);
            chk("rd_rvalid", ldr_rvalid, (i > 0) ? 1 : 0);
            if (i > 0) begin
                chk("rd_rdata", ldr_rdata, prog[i-1]);
                chk("rd_err",   ldr_err,   0);
            end
            tick();
        end

        // ldr_done together with a write; fetch granted next cycle
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'hC; ldr_wdata = 32'h00000013; ldr_done = 1'b1;
        #1;
        chk("done_wr_gnt",  ldr_gnt,   1);
        chk("done_fgnt",    fetch_gnt, 0);
        chk("done_boot",    boot,      1);
        tick();
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_done = 1'b0;
        #1;
        chk("run_boot",      boot,       0);
        chk("run_fgnt",      fetch_gnt,  1);
        chk("run_mem_addr",  mem_addr,   0);
        chk("done_wr_ack",   ldr_rvalid, 1);
        chk("done_wr_err",   ldr_err,    0);
        tick();
        fetch_req = 1'b0;
        #1;
        chk("run_frvalid", fetch_rvalid, 1);
        chk("run_frdata",  fetch_rdata,  32'h03200793);
        chk("run_ferr",    fetch_err,    0);
        tick();

        // starvation bound: L,L,L,L,F repeating
        fetch_req = 1'b1; fetch_addr = 32'h8;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h4;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("burst_fgnt", fetch_gnt, (i % 5 == 4) ? 1 : 0);
            chk("burst_lgnt", ldr_gnt,   (i % 5 == 4) ? 0 : 1);
            chk("burst_frvalid", fetch_rvalid, (i > 0 && (i - 1) % 5 == 4) ? 1 : 0);
            chk("burst_lrvalid", ldr_rvalid,   (i > 0 && (i - 1) % 5 != 4) ? 1 : 0);
            if (i > 0 && (i - 1) % 5 == 4) chk("burst_frdata", fetch_rdata, 32'h00E7F6B3);
            if (i > 0 && (i - 1) % 5 != 4) chk("burst_lrdata", ldr_rdata,   32'h03100713);
            tick();
        end
        fetch_req = 1'b0; ldr_req = 1'b0;
        #1;
        chk("burst_last_frvalid", fetch_rvalid, 1);
        chk("burst_last_frdata",  fetch_rdata,  32'h00E7F6B3);
        tick();

        // misaligned fetch
        fetch_req = 1'b1; fetch_addr = 32'h2;
        #1;
        chk("ferr_gnt",    fetch_gnt, 1);
        chk("ferr_mem_en", mem_en,    0);
        tick();
        fetch_req = 1'b0;
        #1;
        chk("ferr_rvalid", fetch_rvalid, 1);
        chk("ferr_err",    fetch_err,    1);
        chk("ferr_rdata",  fetch_rdata,  0);
        tick();

        // out-of-range loader write aliases word 0 if not blocked
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h1000; ldr_wdata = 32'hDEADBEEF;
        #1;
        chk("lerr_gnt",    ldr_gnt, 1);
        chk("lerr_mem_en", mem_en,  0);
        tick();
        ldr_we = 1'b0; ldr_addr = 32'h0;
        #1;
        chk("lerr_rvalid", ldr_rvalid, 1);
        chk("lerr_err",    ldr_err,    1);
        chk("lerr_rdata",  ldr_rdata,  0);
        tick();
        ldr_we = 1'b1; ldr_addr = 32'h10; ldr_wdata = 32'h12345678;
        #1;
        chk("lerr_unchanged", ldr_rdata, 32'h03200793);
        chk("lerr_rd_err",    ldr_err,   0);
        tick();

        // write then read same address back-to-back
        ldr_we = 1'b0;
        #1;
        chk("wr_rd_ack", ldr_rvalid, 1);
        tick();
        ldr_req = 1'b0;
        #1;
        chk("wr_rd_data", ldr_rdata, 32'h12345678);
        tick();

        // reset while a fetch read is in flight
        fetch_req = 1'b1; fetch_addr = 32'h4;
        #1;
        chk("rstmid_gnt", fetch_gnt, 1);
        tick();
        fetch_req = 1'b0; rst = 1'b1;
        #1;
        chk("rstmid_rvalid_in_rst", fetch_rvalid, 0);
        chk("rstmid_rdata_in_rst",  fetch_rdata,  0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid_rvalid_after", fetch_rvalid, 0);
        chk("rstmid_boot",         boot,         1);
        fetch_req = 1'b1; fetch_addr = 32'h0;
        #1;
        chk("rstmid_fetch_blocked", fetch_gnt, 0);
        tick();
        fetch_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
